// File: rtl/reg_file_pkg.sv
// Shared defaults and word type for the reg_file register file.
package reg_file_pkg;

  localparam int REGFILE_WIDTH = 16;
  localparam int REGFILE_DEPTH = 8;
  localparam int REGFILE_ADDR  = 3;

  typedef logic [REGFILE_WIDTH-1:0] regfile_word_t;

endpackage

// File: rtl/reg_file_row.sv
// One storage word of reg_file: write-enabled register, async active-high reset.
module reg_file_row
  import reg_file_pkg::*;
#(
  parameter int Width = REGFILE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Single-port register file with registered read; write wins over read.
// Optional RdValid output when REGFILE_RD_VALID_EN is defined.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int Width = REGFILE_WIDTH,
  parameter int Depth = REGFILE_DEPTH,
  parameter int ADDR  = REGFILE_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Wr_En,
  input  logic             Rd_En,
  input  logic [ADDR-1:0]  Address,
  input  logic [Width-1:0] WrData,
`ifdef REGFILE_RD_VALID_EN
  output logic             RdValid,
`endif
  output logic [Width-1:0] RdData
);

  logic [Width-1:0] row_q [Depth];
  logic [Depth-1:0] row_we;
  logic [Width-1:0] rd_word;
  logic             rd_accept;

  assign rd_accept = Rd_En && !Wr_En;

  // Out-of-range addresses match no row: writes are dropped, reads yield 0.
  for (genvar i = 0; i < Depth; i++) begin : g_row
    assign row_we[i] = Wr_En && (Address == ADDR'(i));

    reg_file_row #(
      .Width(Width)
    ) u_row (
      .clk  (clk),
      .reset(reset),
      .we   (row_we[i]),
      .d    (WrData),
      .q    (row_q[i])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (Address == ADDR'(i)) begin
        rd_word = row_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RdData <= '0;
    end else if (rd_accept) begin
      RdData <= rd_word;
    end
  end

`ifdef REGFILE_RD_VALID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RdValid <= 1'b0;
    end else begin
      RdValid <= rd_accept;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file (default 16x8 configuration).
module tb_reg_file;
  import reg_file_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Wr_En = 1'b0;
  logic          Rd_En = 1'b0;
  logic [2:0]    Address = '0;
  regfile_word_t WrData = '0;
  regfile_word_t RdData;
`ifdef REGFILE_RD_VALID_EN
  logic          RdValid;
`endif

  int checks = 0;
  int errors = 0;

  reg_file #(
    .Width(16),
    .Depth(8),
    .ADDR (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Wr_En  (Wr_En),
    .Rd_En  (Rd_En),
    .Address(Address),
    .WrData (WrData),
`ifdef REGFILE_RD_VALID_EN
    .RdValid(RdValid),
`endif
    .RdData (RdData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic          re;
    logic [2:0]    addr;
    regfile_word_t data;
    regfile_word_t exp_rd;
    logic          exp_v;
  } vec_t;

  vec_t vecs[16];

  task automatic check16(input string name, input regfile_word_t act, input regfile_word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_valid(input string name, input logic exp);
`ifdef REGFILE_RD_VALID_EN
    checks++;
    if (RdValid !== exp) begin
      errors++;
      $display("FAIL %s: RdValid got %b expected %b", name, RdValid, exp);
    end
`else
    if (name.len() == 0 && exp) $display("unused");
`endif
  endtask

  // Drive at the falling edge, sample 1 ns after the next rising edge.
  task automatic access(input logic we, input logic re, input logic [2:0] addr,
                        input regfile_word_t data);
    Wr_En = we;
    Rd_En = re;
    Address = addr;
    WrData = data;
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      access(1'b0, 1'b1, 3'(a), 16'h0);
      check16($sformatf("%s_rd%0d", tag, a), RdData, 16'h0000);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'd2, 16'h0002, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd3, 16'h0003, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 16'h0000, 16'h0002, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 16'h0000, 16'h0003, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'd2, 16'hBEEF, 16'h0003, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'd2, 16'h0000, 16'hBEEF, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 16'hFFFF, 16'hBEEF, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd7, 16'hFFFF, 16'hBEEF, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 3'd1, 16'h5555, 16'hBEEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 3'd7, 16'hAAAA, 16'hBEEF, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 16'h1111, 16'hBEEF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'd0, 16'h0000, 16'hFFFF, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 3'd7, 16'h0000, 16'hFFFF, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 3'd5, 16'h1234, 16'h0000, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'd5, 16'h0000, 16'h1234, 1'b1};

    // Reset held from time zero, before any clock edge.
    #2;
    check16("reset_rd", RdData, 16'h0000);
    check_valid("reset_valid", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    read_all_zero("post_reset");

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].data);
      check16($sformatf("vec%0d_rd", i), RdData, vecs[i].exp_rd);
      check_valid($sformatf("vec%0d_valid", i), vecs[i].exp_v);
    end

    // Write then reset mid-cycle before reading it back.
    @(negedge clk);
    access(1'b1, 1'b0, 3'd4, 16'hA5A5);
    check16("pre_reset_hold", RdData, 16'h1234);
    @(negedge clk);
    Wr_En = 1'b0;
    Rd_En = 1'b1;
    Address = 3'd4;
    #1;
    reset = 1'b1;
    #2;
    check16("async_reset_rd", RdData, 16'h0000);
    check_valid("async_reset_valid", 1'b0);
    #3;
    check16("reset_over_edge_rd", RdData, 16'h0000);
    reset = 1'b0;
    read_all_zero("after_async");

    @(negedge clk);
    access(1'b1, 1'b0, 3'd6, 16'hC3C3);
    check_valid("write_only_valid", 1'b0);
    @(negedge clk);
    access(1'b0, 1'b1, 3'd6, 16'h0);
    check16("final_rd6", RdData, 16'hC3C3);
    check_valid("final_valid", 1'b1);
    @(negedge clk);
    access(1'b0, 1'b0, 3'd6, 16'h0);
    check_valid("valid_one_cycle", 1'b0);
    check16("final_hold", RdData, 16'hC3C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
